// File: rtl/r_updnld_bounded.sv
// r_updnld_bounded: parametrised up/down/load register with step size,
// programmable LO/HI bounds (wrap or saturate), a shadow copy for
// save/restore/swap, status flags and a tristate transfer-bus output.
// All state changes on the falling edge of clk, like the other CPU registers.
module r_updnld_bounded #(
  parameter int                 WIDTH     = 16,
  parameter int                 STEPW     = 4,
  parameter bit                 SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             reg_load,
  input  logic             inc,
  input  logic             dec,
  input  logic [STEPW-1:0] step,
  input  logic             lim_load,
  input  logic             lim_sel,
  input  logic             save,
  input  logic             restore,
  input  logic             ovf_clr,
  input  logic [WIDTH-1:0] XferBusIn,
  input  logic             reg_write,
  output wire  [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] AddrOut,
  output logic             zero,
  output logic             at_lo,
  output logic             at_hi,
  output logic             ovf
);

  logic [WIDTH-1:0] data_reg, data_next;
  logic [WIDTH-1:0] shadow_reg, shadow_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic             ovf_reg, ovf_next;

  logic [WIDTH-1:0] step_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             inc_over;
  logic             dec_under;
  logic             step_nz;
  logic [WIDTH-1:0] bound_inc;
  logic [WIDTH-1:0] bound_dec;

  // One extra bit keeps the carry (inc) and the borrow/sign (dec) visible,
  // so a carry out of WIDTH bits counts as exceeding HI and a negative
  // difference counts as falling below LO.
  assign step_ext  = WIDTH'(step);
  assign sum       = {1'b0, data_reg} + {1'b0, step_ext};
  assign diff      = {1'b0, data_reg} - {1'b0, step_ext};
  assign inc_over  = sum > {1'b0, hi_reg};
  assign dec_under = diff[WIDTH] || (diff[WIDTH-1:0] < lo_reg);
  assign step_nz   = |step;

  // Boundary action: wrap jumps to the opposite bound, saturate clamps.
  assign bound_inc = SATURATE ? hi_reg : lo_reg;
  assign bound_dec = SATURATE ? lo_reg : hi_reg;

  // Next-state selection: restore > reg_load > inc/dec > hold; shadow,
  // bounds and ovf are updated independently of the data command.
  always_comb begin
    data_next   = data_reg;
    shadow_next = shadow_reg;
    lo_next     = lo_reg;
    hi_next     = hi_reg;
    ovf_next    = ovf_reg & ~ovf_clr;

    // Shadow always captures the pre-edge value, which makes save+restore a swap.
    if (save) begin
      shadow_next = data_reg;
    end

    if (restore) begin
      data_next = shadow_reg;
    end else if (reg_load) begin
      data_next = XferBusIn;
    end else if (inc && !dec && step_nz) begin
      if (inc_over) begin
        data_next = bound_inc;
        ovf_next  = 1'b1;
      end else begin
        data_next = sum[WIDTH-1:0];
      end
    end else if (dec && !inc && step_nz) begin
      if (dec_under) begin
        data_next = bound_dec;
        ovf_next  = 1'b1;
      end else begin
        data_next = diff[WIDTH-1:0];
      end
    end

    // New bounds take effect next cycle; this cycle's check used the old ones.
    if (lim_load) begin
      if (lim_sel) begin
        hi_next = XferBusIn;
      end else begin
        lo_next = XferBusIn;
      end
    end
  end

  // Falling-edge state register with synchronous clear taking priority.
  always_ff @(negedge clk) begin
    if (clr) begin
      data_reg   <= RESET_VAL;
      shadow_reg <= RESET_VAL;
      lo_reg     <= '0;
      hi_reg     <= '1;
      ovf_reg    <= 1'b0;
    end else begin
      data_reg   <= data_next;
      shadow_reg <= shadow_next;
      lo_reg     <= lo_next;
      hi_reg     <= hi_next;
      ovf_reg    <= ovf_next;
    end
  end

  // Status flags and address path follow the stored value combinationally.
  assign AddrOut = data_reg;
  assign zero    = (data_reg == '0);
  assign at_lo   = (data_reg == lo_reg);
  assign at_hi   = (data_reg == hi_reg);
  assign ovf     = ovf_reg;

  // The shared bus is released (all Z) whenever this register is not writing.
  assign Out = reg_write ? data_reg : {WIDTH{1'bz}};

endmodule

// File: tb/tb_r_updnld_bounded.sv
// Bench for r_updnld_bounded: one wrap-mode and one saturate-mode instance
// share the same stimulus. Each command pushes hand-computed expectations
// into a queue; a monitor on the rising edge (half a cycle after the
// falling-edge update) pops and compares them.
module tb_r_updnld_bounded;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         clr, reg_load, inc, dec, lim_load, lim_sel;
  logic         save, restore, ovf_clr, reg_write;
  logic [3:0]   step;
  logic [W-1:0] bus_in;

  // Bus nets are pulled up so a released bus reads as all ones.
  tri1  [W-1:0] out_w;
  tri1  [W-1:0] out_s;
  logic [W-1:0] addr_w, addr_s;
  logic         zero_w, zero_s, lo_w, lo_s, hi_w, hi_s, ovf_w, ovf_s;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string        name;
    bit           sel;     // 0 = wrap instance, 1 = saturate instance
    logic [W-1:0] addr;
    logic         z;
    logic         lo;
    logic         hi;
    logic         ov;
    logic [W-1:0] out;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  r_updnld_bounded #(.WIDTH(W), .STEPW(4), .SATURATE(1'b0), .RESET_VAL('0)) dut_w (
    .clk(clk), .clr(clr), .reg_load(reg_load), .inc(inc), .dec(dec), .step(step),
    .lim_load(lim_load), .lim_sel(lim_sel), .save(save), .restore(restore),
    .ovf_clr(ovf_clr), .XferBusIn(bus_in), .reg_write(reg_write), .Out(out_w),
    .AddrOut(addr_w), .zero(zero_w), .at_lo(lo_w), .at_hi(hi_w), .ovf(ovf_w)
  );

  r_updnld_bounded #(.WIDTH(W), .STEPW(4), .SATURATE(1'b1), .RESET_VAL('0)) dut_s (
    .clk(clk), .clr(clr), .reg_load(reg_load), .inc(inc), .dec(dec), .step(step),
    .lim_load(lim_load), .lim_sel(lim_sel), .save(save), .restore(restore),
    .ovf_clr(ovf_clr), .XferBusIn(bus_in), .reg_write(reg_write), .Out(out_s),
    .AddrOut(addr_s), .zero(zero_s), .at_lo(lo_s), .at_hi(hi_s), .ovf(ovf_s)
  );

  task automatic chk(input string name, input string field,
                     input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", name, field, act, req);
    end
  endtask

  // Monitor: compare everything queued for this cycle against the outputs.
  always @(posedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel == 1'b0) begin
        chk(e.name, "addr", addr_w, e.addr);
        chk(e.name, "zero", W'(zero_w), W'(e.z));
        chk(e.name, "at_lo", W'(lo_w), W'(e.lo));
        chk(e.name, "at_hi", W'(hi_w), W'(e.hi));
        chk(e.name, "ovf", W'(ovf_w), W'(e.ov));
        chk(e.name, "out", out_w, e.out);
      end else begin
        chk(e.name, "addr", addr_s, e.addr);
        chk(e.name, "zero", W'(zero_s), W'(e.z));
        chk(e.name, "at_lo", W'(lo_s), W'(e.lo));
        chk(e.name, "at_hi", W'(hi_s), W'(e.hi));
        chk(e.name, "ovf", W'(ovf_s), W'(e.ov));
        chk(e.name, "out", out_s, e.out);
      end
      $display("check %-14s inst=%0d addr=%h z=%0b lo=%0b hi=%0b ovf=%0b",
               e.name, e.sel, e.addr, e.z, e.lo, e.hi, e.ov);
    end
  end

  task automatic idle();
    clr = 0; reg_load = 0; inc = 0; dec = 0; step = '0; lim_load = 0;
    lim_sel = 0; save = 0; restore = 0; ovf_clr = 0; bus_in = '0;
  endtask

  // Begin a command just after the rising edge.
  task automatic start();
    @(posedge clk);
    #1;
  endtask

  // Let the falling edge apply the command, then return inputs to idle.
  task automatic go();
    @(negedge clk);
    #1;
    idle();
  endtask

  // Queue an expectation; Out is expected to be data while driving,
  // otherwise the pulled-up released bus.
  task automatic expect_st(input string name, input bit sel, input logic [W-1:0] addr,
                           input logic z, input logic lo, input logic hi, input logic ov);
    exp_t e;
    e.name = name; e.sel = sel; e.addr = addr;
    e.z = z; e.lo = lo; e.hi = hi; e.ov = ov;
    e.out = reg_write ? addr : '1;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    reg_write = 0;

    // Reset and bus output
    start(); clr = 1; go();
    expect_st("reset_w", 0, 16'h0000, 1, 1, 0, 0);
    expect_st("reset_s", 1, 16'h0000, 1, 1, 0, 0);
    start(); reg_write = 1; go();
    expect_st("out_drive0", 0, 16'h0000, 1, 1, 0, 0);

    // Load and step
    start(); reg_load = 1; bus_in = 16'h1234; go();
    expect_st("load_1234", 0, 16'h1234, 0, 0, 0, 0);
    start(); reg_write = 0; inc = 1; step = 4; go();
    expect_st("inc4", 0, 16'h1238, 0, 0, 0, 0);
    start(); dec = 1; step = 8; go();
    expect_st("dec8", 0, 16'h1230, 0, 0, 0, 0);
    start(); inc = 1; dec = 1; step = 5; go();
    expect_st("inc_dec_hold", 0, 16'h1230, 0, 0, 0, 0);
    start(); inc = 1; step = 0; go();
    expect_st("inc_step0", 0, 16'h1230, 0, 0, 0, 0);

    // Wrap mode bounds: LO=0100, HI=01FF
    start(); lim_load = 1; lim_sel = 0; bus_in = 16'h0100; go();
    expect_st("set_lo", 0, 16'h1230, 0, 0, 0, 0);
    start(); lim_load = 1; lim_sel = 1; bus_in = 16'h01FF; go();
    expect_st("set_hi", 0, 16'h1230, 0, 0, 0, 0);
    start(); reg_load = 1; bus_in = 16'h01FE; go();
    expect_st("load_01fe", 0, 16'h01FE, 0, 0, 0, 0);
    start(); inc = 1; step = 4; go();
    expect_st("wrap_inc", 0, 16'h0100, 0, 1, 0, 1);
    start(); ovf_clr = 1; go();
    expect_st("ovf_clr", 0, 16'h0100, 0, 1, 0, 0);
    start(); dec = 1; step = 1; go();
    expect_st("wrap_dec", 0, 16'h01FF, 0, 0, 1, 1);
    start(); ovf_clr = 1; inc = 1; step = 1; go();
    expect_st("set_beats_clr", 0, 16'h0100, 0, 1, 0, 1);
    start(); ovf_clr = 1; go();
    expect_st("ovf_clr2", 0, 16'h0100, 0, 1, 0, 0);
    start(); reg_load = 1; bus_in = 16'h0300; go();
    expect_st("load_above_hi", 0, 16'h0300, 0, 0, 0, 0);
    start(); inc = 1; step = 1; go();
    expect_st("inc_above_hi", 0, 16'h0100, 0, 1, 0, 1);
    start(); dec = 1; step = 1; lim_load = 1; lim_sel = 0; bus_in = 16'h0000; go();
    expect_st("old_bound_used", 0, 16'h01FF, 0, 0, 1, 1);

    // Saturate vs wrap with default bounds
    start(); clr = 1; go();
    expect_st("reset2_w", 0, 16'h0000, 1, 1, 0, 0);
    expect_st("reset2_s", 1, 16'h0000, 1, 1, 0, 0);
    start(); reg_load = 1; bus_in = 16'hFFFE; go();
    expect_st("load_fffe_s", 1, 16'hFFFE, 0, 0, 0, 0);
    start(); inc = 1; step = 3; go();
    expect_st("sat_inc", 1, 16'hFFFF, 0, 0, 1, 1);
    expect_st("carry_wrap", 0, 16'h0000, 1, 1, 0, 1);
    start(); reg_load = 1; bus_in = 16'h0001; go();
    expect_st("load_0001_s", 1, 16'h0001, 0, 0, 0, 1);
    start(); dec = 1; step = 2; go();
    expect_st("sat_dec", 1, 16'h0000, 1, 1, 0, 1);
    expect_st("borrow_wrap", 0, 16'hFFFF, 0, 0, 1, 1);

    // Shadow register
    start(); clr = 1; go();
    expect_st("reset3", 0, 16'h0000, 1, 1, 0, 0);
    start(); reg_load = 1; bus_in = 16'hAAAA; go();
    expect_st("load_aaaa", 0, 16'hAAAA, 0, 0, 0, 0);
    start(); save = 1; go();
    expect_st("save", 0, 16'hAAAA, 0, 0, 0, 0);
    start(); reg_load = 1; bus_in = 16'h5555; go();
    expect_st("load_5555", 0, 16'h5555, 0, 0, 0, 0);
    start(); save = 1; restore = 1; go();
    expect_st("swap", 0, 16'hAAAA, 0, 0, 0, 0);
    start(); restore = 1; go();
    expect_st("restore", 0, 16'h5555, 0, 0, 0, 0);

    // Priority
    start(); reg_load = 1; bus_in = 16'h1111; go();
    expect_st("load_1111", 0, 16'h1111, 0, 0, 0, 0);
    start(); restore = 1; reg_load = 1; bus_in = 16'h2222; inc = 1; step = 1; go();
    expect_st("restore_prio", 0, 16'h5555, 0, 0, 0, 0);
    start(); reg_load = 1; bus_in = 16'h7000; go();
    expect_st("load_7000", 0, 16'h7000, 0, 0, 0, 0);
    start(); save = 1; inc = 1; step = 1; go();
    expect_st("save_with_inc", 0, 16'h7001, 0, 0, 0, 0);
    start(); restore = 1; go();
    expect_st("restore_7000", 0, 16'h7000, 0, 0, 0, 0);

    // Reset mid-operation
    start(); reg_load = 1; bus_in = 16'hFFFF; go();
    expect_st("load_ffff", 0, 16'hFFFF, 0, 0, 1, 0);
    start(); inc = 1; step = 1; go();
    expect_st("wrap_to_lo", 0, 16'h0000, 1, 1, 0, 1);
    start(); clr = 1; reg_load = 1; bus_in = 16'h9999; lim_load = 1; lim_sel = 1;
    inc = 1; step = 1; save = 1; go();
    expect_st("clr_prio", 0, 16'h0000, 1, 1, 0, 0);
    start(); reg_load = 1; bus_in = 16'hFFFF; go();
    expect_st("hi_default", 0, 16'hFFFF, 0, 0, 1, 0);
    start(); restore = 1; go();
    expect_st("shadow_reset", 0, 16'h0000, 1, 1, 0, 0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
